// File: rtl/cajero_pkg.sv
// Shared definitions for the shared-account controller: FSM encoding,
// transaction type codes and default datapath widths.
package cajero_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEER     = 2'd1,
    ESPERA   = 2'd2,
    ESCRIBIR = 2'd3
  } estado_t;

  localparam logic DEPOSITO = 1'b0;
  localparam logic RETIRO   = 1'b1;

  localparam int W_BAL_DEF   = 64;
  localparam int W_MONTO_DEF = 32;

endpackage

// File: rtl/rr_arbitro.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around. The rotating pointer lives in the parent.
module rr_arbitro #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] id,
  output logic          valid
);

  always_comb begin
    logic [IW-1:0] idx;
    grant = '0;
    id    = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        id         = idx;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_saldos.sv
// Shared-account controller: grants one cashier terminal at a time and runs a
// read-check-write sequence on the external balance RAM before the next grant.
module arbitro_saldos
  import cajero_pkg::*;
#(
  parameter int N_TERM    = 4,
  parameter int N_CUENTAS = 16,
  parameter int W_BAL     = W_BAL_DEF,
  parameter int W_MONTO   = W_MONTO_DEF,
  localparam int AW       = $clog2(N_CUENTAS),
  localparam int IW       = $clog2(N_TERM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      habilitar,
  input  logic [N_TERM-1:0]         req,
  input  logic [N_TERM-1:0]         req_tipo,
  input  logic [N_TERM*AW-1:0]      req_cuenta,
  input  logic [N_TERM*W_MONTO-1:0] req_monto,
  output logic [N_TERM-1:0]         ack,
  output logic                      mem_rd_en,
  output logic [AW-1:0]             mem_addr,
  input  logic [W_BAL-1:0]          mem_rd_data,
  output logic                      mem_wr_en,
  output logic [W_BAL-1:0]          mem_wr_data,
  output logic                      resp_valid,
  output logic [IW-1:0]             resp_id,
  output logic [W_BAL-1:0]          resp_balance,
  output logic                      fondos_insuficientes,
  output logic                      desborde
);

  // Handshake: a terminal holds req (with stable tipo/cuenta/monto) until it
  // sees its one-cycle ack; the fields are latched at grant, so req may drop
  // in the ack cycle. Every output is a flop loaded from the state it follows,
  // so each state's strobes appear one cycle after that state.
  estado_t             state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, id_q, id_d;
  logic                tipo_q, tipo_d;
  logic [AW-1:0]       cuenta_q, cuenta_d;
  logic [W_MONTO-1:0]  monto_q, monto_d;

  logic [N_TERM-1:0]   ack_q, ack_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [W_BAL-1:0]    wr_data_q, wr_data_d, rbal_q, rbal_d;
  logic                rv_q, rv_d, fi_q, fi_d, des_q, des_d;
  logic [IW-1:0]       rid_q, rid_d;

  logic [N_TERM-1:0]   arb_grant;
  logic [IW-1:0]       arb_id;
  logic                arb_valid;

  logic [W_BAL:0]      monto_ext, suma;
  logic [W_BAL-1:0]    resta;
  logic                sin_fondos;

  rr_arbitro #(.N(N_TERM), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .id    (arb_id),
    .valid (arb_valid)
  );

  // Carry-out of the widened sum flags an overflowing deposit.
  always_comb begin
    monto_ext                = '0;
    monto_ext[W_MONTO-1:0]   = monto_q;
    suma                     = {1'b0, mem_rd_data} + monto_ext;
    sin_fondos               = monto_ext[W_BAL-1:0] > mem_rd_data;
    resta                    = mem_rd_data - monto_ext[W_BAL-1:0];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    tipo_d    = tipo_q;
    cuenta_d  = cuenta_q;
    monto_d   = monto_q;
    ack_d     = '0;
    rd_en_d   = 1'b0;
    addr_d    = '0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    rv_d      = 1'b0;
    rid_d     = '0;
    rbal_d    = '0;
    fi_d      = 1'b0;
    des_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (habilitar && arb_valid) begin
          id_d     = arb_id;
          tipo_d   = req_tipo[arb_id];
          cuenta_d = req_cuenta[arb_id*AW +: AW];
          monto_d  = req_monto[arb_id*W_MONTO +: W_MONTO];
          ack_d    = arb_grant;
          ptr_d    = (arb_id == IW'(N_TERM-1)) ? '0 : arb_id + 1'b1;
          state_d  = LEER;
        end
      end
      LEER: begin
        rd_en_d = 1'b1;
        addr_d  = cuenta_q;
        state_d = ESPERA;
      end
      ESPERA: begin
        state_d = ESCRIBIR;
      end
      ESCRIBIR: begin
        rv_d    = 1'b1;
        rid_d   = id_q;
        state_d = IDLE;
        case (tipo_q)
          DEPOSITO: begin
            if (suma[W_BAL]) begin
              des_d  = 1'b1;
              rbal_d = mem_rd_data;
            end else begin
              wr_en_d   = 1'b1;
              addr_d    = cuenta_q;
              wr_data_d = suma[W_BAL-1:0];
              rbal_d    = suma[W_BAL-1:0];
            end
          end
          RETIRO: begin
            if (sin_fondos) begin
              fi_d   = 1'b1;
              rbal_d = mem_rd_data;
            end else begin
              wr_en_d   = 1'b1;
              addr_d    = cuenta_q;
              wr_data_d = resta;
              rbal_d    = resta;
            end
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      tipo_q    <= 1'b0;
      cuenta_q  <= '0;
      monto_q   <= '0;
      ack_q     <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rv_q      <= 1'b0;
      rid_q     <= '0;
      rbal_q    <= '0;
      fi_q      <= 1'b0;
      des_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      tipo_q    <= tipo_d;
      cuenta_q  <= cuenta_d;
      monto_q   <= monto_d;
      ack_q     <= ack_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rv_q      <= rv_d;
      rid_q     <= rid_d;
      rbal_q    <= rbal_d;
      fi_q      <= fi_d;
      des_q     <= des_d;
    end
  end

  assign ack                  = ack_q;
  assign mem_rd_en            = rd_en_q;
  assign mem_addr             = addr_q;
  assign mem_wr_en            = wr_en_q;
  assign mem_wr_data          = wr_data_q;
  assign resp_valid           = rv_q;
  assign resp_id              = rid_q;
  assign resp_balance         = rbal_q;
  assign fondos_insuficientes = fi_q;
  assign desborde             = des_q;

endmodule

// File: tb/tb_arbitro_saldos.sv
// Bench for arbitro_saldos: balance RAM model, transaction-level reference
// model compared every cycle, directed scenarios and randomized traffic.
module tb_arbitro_saldos;

  localparam int N  = 4;
  localparam int NC = 16;
  localparam int AW = 4;
  localparam int WB = 64;
  localparam int WM = 32;
  localparam logic [WB-1:0] MAXB = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              habilitar;
  logic [N-1:0]      req, req_tipo;
  logic [N*AW-1:0]   req_cuenta;
  logic [N*WM-1:0]   req_monto;
  logic [N-1:0]      ack;
  logic              mem_rd_en, mem_wr_en, resp_valid, fondos_insuficientes, desborde;
  logic [AW-1:0]     mem_addr;
  logic [WB-1:0]     mem_rd_data, mem_wr_data, resp_balance;
  logic [1:0]        resp_id;

  arbitro_saldos #(.N_TERM(N), .N_CUENTAS(NC), .W_BAL(WB), .W_MONTO(WM)) dut (
    .clk                  (clk),
    .reset                (rst_n),
    .habilitar            (habilitar),
    .req                  (req),
    .req_tipo             (req_tipo),
    .req_cuenta           (req_cuenta),
    .req_monto            (req_monto),
    .ack                  (ack),
    .mem_rd_en            (mem_rd_en),
    .mem_addr             (mem_addr),
    .mem_rd_data          (mem_rd_data),
    .mem_wr_en            (mem_wr_en),
    .mem_wr_data          (mem_wr_data),
    .resp_valid           (resp_valid),
    .resp_id              (resp_id),
    .resp_balance         (resp_balance),
    .fondos_insuficientes (fondos_insuficientes),
    .desborde             (desborde)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- balance RAM (1-cycle read) ----------------
  logic [WB-1:0] ram [NC];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [WB-1:0] ld_val = '0;

  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_val;
    else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  // ---------------- reference model ----------------
  logic [WB-1:0] saldo_ref [NC];
  int            fase = 0, mptr = 0, m_id = 0, pick = 0;
  logic          m_tipo = 1'b0;
  logic [AW-1:0] m_cta = '0;
  logic [WM-1:0] m_monto = '0;
  logic [WB-1:0] sal = '0;
  logic [N-1:0]  e_ack = '0;
  logic          e_rd_en = 0, e_wr_en = 0, e_rv = 0, e_fi = 0, e_des = 0;
  logic [AW-1:0] e_addr = '0;
  logic [WB-1:0] e_wr_data = '0, e_rbal = '0;
  logic [1:0]    e_rid = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase = 0; mptr = 0;
      e_ack = '0; e_rd_en = 0; e_addr = '0; e_wr_en = 0; e_wr_data = '0;
      e_rv = 0; e_rid = '0; e_rbal = '0; e_fi = 0; e_des = 0;
    end else begin
      e_ack = '0; e_rd_en = 0; e_addr = '0; e_wr_en = 0; e_wr_data = '0;
      e_rv = 0; e_rid = '0; e_rbal = '0; e_fi = 0; e_des = 0;
      if (ld_en) saldo_ref[ld_addr] = ld_val;
      if (fase == 0) begin
        if (habilitar && req != '0) begin
          pick = -1;
          for (int k = 0; k < N; k++)
            if (pick < 0 && req[2'((mptr + k) % N)]) pick = (mptr + k) % N;
          m_id    = pick;
          m_tipo  = req_tipo[2'(pick)];
          m_cta   = req_cuenta[pick*AW +: AW];
          m_monto = req_monto[pick*WM +: WM];
          e_ack[2'(pick)] = 1'b1;
          mptr = (pick + 1) % N;
          fase = 1;
        end
      end else if (fase == 1) begin
        e_rd_en = 1; e_addr = m_cta; fase = 2;
      end else if (fase == 2) begin
        fase = 3;
      end else begin
        sal = saldo_ref[m_cta];
        e_rv = 1; e_rid = 2'(m_id); fase = 0;
        if (m_tipo == 1'b0) begin
          if ({32'd0, m_monto} > MAXB - sal) begin
            e_des = 1; e_rbal = sal;
          end else begin
            e_wr_en = 1; e_addr = m_cta; e_wr_data = sal + {32'd0, m_monto};
            e_rbal = e_wr_data; saldo_ref[m_cta] = e_wr_data;
          end
        end else begin
          if ({32'd0, m_monto} > sal) begin
            e_fi = 1; e_rbal = sal;
          end else begin
            e_wr_en = 1; e_addr = m_cta; e_wr_data = sal - {32'd0, m_monto};
            e_rbal = e_wr_data; saldo_ref[m_cta] = e_wr_data;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("ack", ack, e_ack);
    chk("mem_rd_en", mem_rd_en, e_rd_en);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wr_en", mem_wr_en, e_wr_en);
    chk("mem_wr_data", mem_wr_data, e_wr_data);
    chk("resp_valid", resp_valid, e_rv);
    chk("resp_id", resp_id, e_rid);
    chk("resp_balance", resp_balance, e_rbal);
    chk("fondos_insuficientes", fondos_insuficientes, e_fi);
    chk("desborde", desborde, e_des);
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int t, input logic tipo, input int cta, input logic [WM-1:0] monto);
    req_tipo[t]             = tipo;
    req_cuenta[t*AW +: AW]  = AW'(cta);
    req_monto[t*WM +: WM]   = monto;
    req[t]                  = 1'b1;
  endtask

  task automatic cargar(input int a, input logic [WB-1:0] v);
    ld_en = 1'b1; ld_addr = AW'(a); ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic txn(input int t, input logic tipo, input int cta, input logic [WM-1:0] monto,
                     output logic [WB-1:0] bal, output logic fi, output logic des,
                     output logic wrote, output int lat);
    int n;
    set_req(t, tipo, cta, monto);
    n = 0;
    @(negedge clk);
    while (!ack[t] && n < 40) begin @(negedge clk); n++; end
    chk("txn_ack", ack[t], 1'b1);
    req[t] = 1'b0;
    lat = 0; wrote = 0; bal = '0; fi = 0; des = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_wr_en) wrote = 1;
      if (resp_valid) begin
        bal = resp_balance; fi = fondos_insuficientes; des = desborde;
        break;
      end
    end
  endtask

  task automatic wait_ack_drop(input int t, input string name);
    int n;
    n = 0;
    while (!ack[t] && n < 40) begin @(negedge clk); n++; end
    chk(name, ack[t], 1'b1);
    req[t] = 1'b0;
  endtask

  // ---------------- scoreboard state ----------------
  logic [WB-1:0] exp_q[$];
  logic [WB-1:0] rd_q[$];

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [WB-1:0] bal;
    logic          fi, des, wrote, prev_rd;
    int            lat, cnt, cyc, got;
    int            ids[8], at[8];
    logic [WB-1:0] v;
    logic [WM-1:0] m;

    rst_n = 1'b0; habilitar = 1'b0; req = '0; req_tipo = '0; req_cuenta = '0; req_monto = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, '0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_balance", resp_balance, 0);
    rst_n = 1'b1;
    for (int a = 0; a < NC; a++) cargar(a, '0);

    // deposit 100 onto 500
    cargar(3, 64'd500);
    habilitar = 1'b1;
    txn(0, 1'b0, 3, 32'd100, bal, fi, des, wrote, lat);
    chk("dep_bal", bal, 64'd600);
    chk("dep_lat", lat, 3);
    chk("dep_wrote", wrote, 1);
    chk("dep_flags", {fi, des}, 2'b00);
    @(negedge clk);
    chk("dep_ram", ram[3], 64'd600);

    // withdrawal larger than balance, then exactly equal
    txn(0, 1'b1, 3, 32'd700, bal, fi, des, wrote, lat);
    chk("ret_big_bal", bal, 64'd600);
    chk("ret_big_fi", fi, 1);
    chk("ret_big_nowrite", wrote, 0);
    txn(0, 1'b1, 3, 32'd600, bal, fi, des, wrote, lat);
    chk("ret_eq_bal", bal, 64'd0);
    chk("ret_eq_fi", fi, 0);
    chk("ret_eq_wrote", wrote, 1);
    @(negedge clk);
    chk("ret_eq_ram", ram[3], 64'd0);

    // deposit overflow
    cargar(7, MAXB);
    txn(0, 1'b0, 7, 32'd1, bal, fi, des, wrote, lat);
    chk("ovf_des", des, 1);
    chk("ovf_bal", bal, MAXB);
    chk("ovf_nowrite", wrote, 0);

    // habilitar low blocks grants
    habilitar = 1'b0;
    set_req(2, 1'b0, 8, 32'd5);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (ack != '0) cnt++; end
    chk("hold_no_ack", cnt, 0);
    habilitar = 1'b1;
    @(negedge clk);
    wait_ack_drop(2, "hold_release_ack");
    repeat (5) @(negedge clk);

    // fairness from a fresh reset
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    for (int t = 0; t < N; t++) set_req(t, 1'b0, 10 + t, 32'd1);
    for (int k = 0; k < 8; k++) begin ids[k] = -1; at[k] = -100; end
    cyc = 0; got = 0;
    while (got < 8 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        for (int t = 0; t < N; t++) if (ack[t]) ids[got] = t;
        at[got] = cyc;
        got++;
        if (got == 8) req = '0;
      end
    end
    req = '0;
    for (int k = 0; k < 8; k++) chk("rr_order", ids[k], k % N);
    for (int k = 1; k < 8; k++) chk("rr_gap", at[k] - at[k-1], 4);
    repeat (6) @(negedge clk);

    // back-to-back same account
    cargar(5, '0);
    exp_q.push_back(64'd10);
    exp_q.push_back(64'd20);
    set_req(1, 1'b0, 5, 32'd10);
    set_req(2, 1'b0, 5, 32'd10);
    prev_rd = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack[1]) req[1] = 1'b0;
      if (ack[2]) req[2] = 1'b0;
      if (prev_rd) rd_q.push_back(mem_rd_data);
      prev_rd = mem_rd_en;
      if (resp_valid) begin
        if (exp_q.size() > 0) chk("b2b_resp", resp_balance, exp_q.pop_front());
        else chk("b2b_extra_resp", resp_valid, 0);
      end
    end
    chk("b2b_pending", exp_q.size(), 0);
    chk("b2b_reads", rd_q.size(), 2);
    if (rd_q.size() >= 2) chk("b2b_second_read", rd_q[1], 64'd10);
    chk("b2b_ram", ram[5], 64'd20);

    // reset in the middle of a transaction
    cargar(9, 64'd50);
    set_req(2, 1'b0, 9, 32'd7);
    @(negedge clk);
    wait_ack_drop(2, "midrst_ack");
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", mem_wr_en, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_ack", ack, '0);
    chk("midrst_rd_en", mem_rd_en, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ram", ram[9], 64'd50);
    set_req(1, 1'b0, 9, 32'd1);
    set_req(3, 1'b0, 9, 32'd2);
    cnt = 0;
    @(negedge clk);
    while (ack == '0 && cnt < 40) begin @(negedge clk); cnt++; end
    chk("postrst_first_grant", ack, 4'b0010);
    repeat (20) begin
      for (int t = 0; t < N; t++) if (ack[t]) req[t] = 1'b0;
      @(negedge clk);
    end
    req = '0;
    repeat (6) @(negedge clk);

    // randomized traffic
    for (int a = 0; a < NC; a++) begin
      case ($urandom_range(0, 2))
        0:       v = 64'($urandom_range(0, 3000));
        1:       v = {$urandom, $urandom};
        default: v = MAXB - 64'($urandom_range(0, 100000));
      endcase
      cargar(a, v);
    end
    repeat (2500) begin
      habilitar = ($urandom_range(0, 9) != 0);
      for (int t = 0; t < N; t++) begin
        if (req[t] && ack[t]) req[t] = 1'b0;
        else if (!req[t] && $urandom_range(0, 3) == 0) begin
          m = ($urandom_range(0, 1) == 0) ? WM'($urandom_range(0, 4000)) : $urandom;
          set_req(t, 1'($urandom_range(0, 1)), int'($urandom_range(0, NC-1)), m);
        end
      end
      @(negedge clk);
    end
    req = '0;
    habilitar = 1'b1;
    repeat (8) @(negedge clk);
    for (int a = 0; a < NC; a++) chk("ram_final", ram[a], saldo_ref[a]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbitro_saldos.md
# arbitro_saldos

Shared-account controller: arbitrates balance transactions from up to `N_TERM` cashier units and sequences read-modify-write access to one external account-balance memory. Each accepted request is read, checked, updated and answered before the next one is granted, so same-account accesses have no hazards. Sits between the per-terminal cashier FSMs and the balance RAM.

## Interface
Parameters:
- `N_TERM`, 4: number of requesting terminals (2..8).
- `N_CUENTAS`, 16: number of accounts; address width `AW = $clog2(N_CUENTAS)`.
- `W_BAL`, 64: balance width.
- `W_MONTO`, 32: amount width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it forces the reset state immediately.
- `habilitar`  in  1  high allows new grants; low blocks new grants but lets an in-flight transaction finish.
- `req`  in  N_TERM  per-terminal request level; held until that terminal's `ack`.
- `req_tipo`  in  N_TERM  per-terminal transaction type: 0 deposito, 1 retiro.
- `req_cuenta`  in  N_TERM*AW  per-terminal account, packed with terminal i at `[i*AW +: AW]`.
- `req_monto`  in  N_TERM*W_MONTO  per-terminal amount, packed the same way.
- `ack`  out  N_TERM  one-hot, one-cycle pulse marking the granted terminal.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  AW  memory address, shared by read and write.
- `mem_rd_data`  in  W_BAL  read data, valid exactly 1 cycle after `mem_rd_en`.
- `mem_wr_en`  out  1  memory write strobe.
- `mem_wr_data`  out  W_BAL  write data.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_id`  out  $clog2(N_TERM)  terminal being answered.
- `resp_balance`  out  W_BAL  resulting balance; on a rejected transaction, the unchanged balance.
- `fondos_insuficientes`  out  1  retiro rejected because the amount exceeds the balance.
- `desborde`  out  1  deposito rejected because the sum overflows `W_BAL`.

## Operation
- FSM states: `IDLE`, `LEER`, `ESPERA`, `ESCRIBIR`.
- **IDLE**
  - When `habilitar` and `|req`: choose the winner round-robin, searching from `ptr`.
  - Latch the winner's id, tipo, cuenta and monto; pulse `ack[id]`.
  - Update `ptr = (id+1) mod N_TERM`; go to `LEER`.
  - Otherwise stay in `IDLE`.
- **LEER**: `mem_rd_en=1`, `mem_addr=cuenta`; go to `ESPERA`.
- **ESPERA**
  - Capture `mem_rd_data` into `saldo`.
  - Compute the result:
    - deposito: `W_BAL+1`-bit sum of `saldo` and the zero-extended monto.
    - retiro: compare `monto > saldo` (zero-extended), then `saldo - monto`.
  - Go to `ESCRIBIR`.
- **ESCRIBIR**
  - Pulse `resp_valid` with `resp_id` and `resp_balance`; go to `IDLE`.
  - Accepted transaction: `mem_wr_en=1`, `mem_addr=cuenta`, `mem_wr_data=new balance`.
  - Rejected transaction: no write; `fondos_insuficientes` or `desborde` is set for that cycle only.
- A retiro with `monto == saldo` is accepted; the result is 0.
- Arithmetic is never modulo: a deposito sum carrying out of bit `W_BAL-1` is rejected.
- `req` is sampled only in `IDLE`. Deasserting `req` in the same cycle as `ack` is legal. `req` toggling outside `IDLE` is ignored.
- Default state (illegal encoding): go to `IDLE`.

## Timing
- Reset values: all outputs 0, `ptr=0`, state `IDLE`, latched fields 0.
- Reset mid-transaction drops the pending write; `mem_wr_en` falls asynchronously and no response is issued.
- Latency: `ack` in cycle T, `mem_rd_en` in T+1, data captured T+2, write and `resp_valid` in T+3.
- The earliest next `ack` is T+4, so throughput is 1 transaction per 4 cycles.
- Same-account back-to-back: the write at T+3 precedes the next read at T+5 or later. Read-after-write is guaranteed without any RAM bypass mode.
- All outputs are registered.
- Fairness: with all `req` high, grants rotate 0,1,2,…,N_TERM-1,0.

## Structure
- Package `cajero_pkg`:
  - state enum encodings;
  - `DEPOSITO=1'b0`, `RETIRO=1'b1`;
  - default widths `W_BAL`, `W_MONTO`.
- Sub-module `rr_arbitro`: parameterized round-robin one-hot picker with inputs `req`, `ptr` and outputs `grant`, `id`, `valid`. It is combinational; the pointer register stays in the parent.

## Test plan
- Reset, then terminal 0 deposits 100 to account 3 holding 500: `ack[0]` at T; write 600 at T+3; `resp_valid`, `resp_id=0`, `resp_balance=600`.
- Retiro 700 from a balance of 600: no `mem_wr_en`; `fondos_insuficientes=1`, `resp_balance=600`. Retiro of exactly 600: accepted, writes 0.
- Deposito 1 to a balance of 2^64-1: `desborde=1`, no write.
- All 4 `req` held high for 8 transactions: `ack` order 0,1,2,3,0,1,2,3; `ack` pulses exactly 4 cycles apart.
- Terminals 1 and 2 each deposit 10 to account 5 (initial 0) back-to-back: final memory value 20, and the second read returns 10.
- `reset` pulled low at T+2 of a transaction: outputs go to 0 immediately, no write and no response; after release, the first grant goes to the lowest requesting index (`ptr=0`).
